uart_boot_loader: RTL and testbench

- Upstream stage of the RV32I core: receives a program image over the UART receive path and writes it word-by-word into instruction memory.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-valid image has been loaded and acknowledged.
- Sits between the uart block and the instruction memory write port. It shares the uart tx path to send a one-byte ACK or NAK.

---
 rtl/uart_boot_loader_if.sv | 27 ++
 rtl/uart_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Signal bundle between the boot loader, the uart and the instruction memory
// write port. The loader drives the master side; the environment drives the slave side.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              send;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    input  rx_data, rx_ready, tx_busy,
    output tx_data, send, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

  modport slave (
    output rx_data, rx_ready, tx_busy,
    input  tx_data, send, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives SYNC / LEN / payload / XOR-checksum frames,
// writes the payload words into instruction memory and releases the CPU
// once a checksum-valid image has been acknowledged.
module uart_boot_loader #(
  parameter int         ADDR_W      = 10,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15
) (
  input logic                clk,
  input logic                clr,
  uart_boot_loader_if.master bus
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RESP, S_DONE
  } state_t;

  state_t            state_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] widx_q;
  logic [1:0]        bidx_q;
  logic [23:0]       word_q;
  logic [7:0]        csum_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              ack_q;
  logic [7:0]        tx_data_q;
  logic              send_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic [15:0] len_d;
  logic [31:0] wdata_d;
  logic [7:0]  csum_d;
  logic        last_word;
  logic        in_frame;
  logic        tmo_hit;

  // Word count as it will be once LEN_H lands, and the word completed by the current byte
  assign len_d     = {bus.rx_data, len_q[7:0]};
  assign wdata_d   = {bus.rx_data, word_q};
  assign csum_d    = csum_q ^ bus.rx_data;
  assign last_word = (16'(widx_q) == (len_q - 16'd1));
  assign in_frame  = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  // The inter-byte timer expires on the TIMEOUT_CYC-th consecutive idle cycle
  assign tmo_hit   = in_frame && !bus.rx_ready && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Frame parser, memory writer and ACK/NAK responder with registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      word_q    <= '0;
      csum_q    <= '0;
      tmo_q     <= '0;
      ack_q     <= 1'b0;
      tx_data_q <= '0;
      send_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      send_q <= 1'b0;
      we_q   <= 1'b0;

      if (in_frame) begin
        tmo_q <= bus.rx_ready ? '0 : tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end

      if (tmo_hit) begin
        ack_q   <= 1'b0;
        state_q <= S_RESP;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.rx_ready && bus.rx_data == SYNC_BYTE) begin
              err_q   <= 1'b0;
              state_q <= S_LEN0;
            end
          end
          S_LEN0: begin
            if (bus.rx_ready) begin
              len_q[7:0] <= bus.rx_data;
              state_q    <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (bus.rx_ready) begin
              len_q[15:8] <= bus.rx_data;
              widx_q      <= '0;
              bidx_q      <= '0;
              csum_q      <= '0;
              if (32'(len_d) > (32'd1 << ADDR_W)) begin
                ack_q   <= 1'b0;
                state_q <= S_RESP;
              end else if (len_d == 16'd0) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (bus.rx_ready) begin
              csum_q <= csum_d;
              bidx_q <= bidx_q + 2'd1;
              unique case (bidx_q)
                2'd0: word_q[7:0]   <= bus.rx_data;
                2'd1: word_q[15:8]  <= bus.rx_data;
                2'd2: word_q[23:16] <= bus.rx_data;
                default: begin
                  we_q    <= 1'b1;
                  addr_q  <= widx_q;
                  wdata_q <= wdata_d;
                  widx_q  <= widx_q + ADDR_W'(1);
                  if (last_word) begin
                    state_q <= S_CSUM;
                  end
                end
              endcase
            end
          end
          S_CSUM: begin
            if (bus.rx_ready) begin
              ack_q   <= (bus.rx_data == csum_q);
              state_q <= S_RESP;
            end
          end
          S_RESP: begin
            if (!bus.tx_busy) begin
              tx_data_q <= ack_q ? ACK_BYTE : NAK_BYTE;
              send_q    <= 1'b1;
              if (ack_q) begin
                state_q <= S_DONE;
              end else begin
                err_q   <= 1'b1;
                state_q <= S_IDLE;
              end
            end
          end
          S_DONE: begin
            hold_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.send       = send_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed and random frames against a
// frame-level reference model of the loader.
module tb_uart_boot_loader;
  localparam int         ADDR_W = 10;
  localparam int         TMO    = 100;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observed traffic
  typedef struct packed { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  int         tx_cyc[$];
  int         cyc = 0;
  int         last_rx_cyc = 0;
  logic       prev_send = 1'b0;
  logic       prev_ack = 1'b0;

  // Monitor on the falling edge: records writes and sends, checks send rules
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_ready) last_rx_cyc <= cyc;
    if (bus.imem_we) wr_q.push_back('{a: bus.imem_addr, d: bus.imem_wdata});
    if (bus.send) begin
      tx_q.push_back(bus.tx_data);
      tx_cyc.push_back(cyc);
      chk("send_while_busy", bus.tx_busy, 0);
      chk("hold_at_send", bus.cpu_hold, 1);
    end
    if (prev_send) chk("send_width", bus.send, 0);
    if (prev_ack) chk("hold_after_ack", bus.cpu_hold, 0);
    prev_send <= bus.send;
    prev_ack  <= bus.send && (bus.tx_data == ACK);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference model state
  bit         model_done = 0;
  bit         model_err = 0;
  logic [31:0] ew[$];
  int          etx;
  logic [7:0]  frm[$];

  task automatic mk(input logic [127:0] v, input int nb);
    frm.delete();
    for (int k = 0; k < nb; k++) frm.push_back(v[8*(nb-1-k) +: 8]);
  endtask

  // Expected writes and response for the frame held in frm
  task automatic model();
    int i;
    int n;
    logic [7:0] x;
    ew.delete();
    etx = -1;
    if (model_done) return;
    i = 0;
    while (i < frm.size() && frm[i] != SYNC) i++;
    if (i + 2 >= frm.size()) return;
    model_err = 0;
    n = int'(frm[i+1]) + 256 * int'(frm[i+2]);
    if (n > (1 << ADDR_W)) begin
      etx = NAK;
      model_err = 1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      ew.push_back({frm[i+6+4*k], frm[i+5+4*k], frm[i+4+4*k], frm[i+3+4*k]});
      x = x ^ frm[i+3+4*k] ^ frm[i+4+4*k] ^ frm[i+5+4*k] ^ frm[i+6+4*k];
    end
    if (frm[i+3+4*n] == x) begin
      etx = ACK;
      model_done = 1;
    end else begin
      etx = NAK;
      model_err = 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    idle(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic play(input int from, input int to, input int gapmax);
    for (int k = from; k < to; k++) send_byte(frm[k], int'($urandom_range(gapmax, 0)));
  endtask

  task automatic clear_obs();
    wr_q.delete();
    tx_q.delete();
    tx_cyc.delete();
  endtask

  task automatic do_reset();
    clr = 1'b0;
    bus.rx_ready = 1'b0;
    bus.tx_busy = 1'b0;
    idle(3);
    clr = 1'b1;
    model_done = 0;
    model_err = 0;
    idle(2);
  endtask

  // Wait (bounded) for the expected response, then compare everything observed
  task automatic check_frame(input string tag);
    int n;
    if (etx >= 0) begin
      for (int c = 0; c < 300 && tx_q.size() == 0; c++) idle(1);
    end else begin
      idle(20);
    end
    idle(3);
    chk({tag, "_wr_count"}, wr_q.size(), ew.size());
    n = (wr_q.size() < ew.size()) ? wr_q.size() : ew.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, "_wr_addr"}, 32'(wr_q[k].a), k);
      chk({tag, "_wr_data"}, wr_q[k].d, ew[k]);
    end
    chk({tag, "_tx_count"}, tx_q.size(), (etx < 0) ? 0 : 1);
    if (etx >= 0 && tx_q.size() > 0) chk({tag, "_tx_byte"}, 32'(tx_q[0]), etx);
    chk({tag, "_done"}, bus.done, model_done);
    chk({tag, "_error"}, bus.error, model_err);
    chk({tag, "_hold"}, bus.cpu_hold, !model_done);
  endtask

  task automatic run(input string tag, input int gapmax);
    clear_obs();
    model();
    play(0, frm.size(), gapmax);
    check_frame(tag);
  endtask

  int         n;
  logic [7:0] x;
  logic [7:0] b;
  int         d;

  initial begin
    clr = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_ready = 1'b0;
    bus.tx_busy = 1'b0;
    idle(2);
    // Reset state
    chk("rst_hold", bus.cpu_hold, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_we", bus.imem_we, 0);
    chk("rst_send", bus.send, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_addr", bus.imem_addr, 0);
    clr = 1'b1;
    idle(2);

    // Bytes without SYNC are ignored
    mk(128'h00_13_FF, 3);
    run("junk", 2);

    // Two-word frame with a bad checksum, then the same frame good
    mk(128'hA5_02_00_13_05_10_00_93_05_20_00_01, 12);
    run("bad_csum", 2);
    mk(128'hA5_02_00_13_05_10_00_93_05_20_00_B0, 12);
    run("good", 2);
    chk("good_w0", (wr_q.size() > 0) ? wr_q[0].d : 32'hX, 32'h00100513);

    // Further SYNC after DONE does nothing
    mk(128'hA5, 1);
    run("after_done", 0);

    // Empty image
    do_reset();
    mk(128'hA5_00_00_00, 4);
    run("empty", 1);

    // Oversized image is refused right after LEN_H
    do_reset();
    mk(128'hA5_01_04, 3);
    run("too_long", 1);

    // Inter-byte timeout
    do_reset();
    clear_obs();
    mk(128'hA5_01_00_13, 4);
    play(0, 4, 1);
    for (int c = 0; c < 300 && tx_q.size() == 0; c++) idle(1);
    idle(3);
    chk("tmo_tx_count", tx_q.size(), 1);
    if (tx_q.size() > 0) begin
      chk("tmo_tx_byte", tx_q[0], NAK);
      d = tx_cyc[0] - last_rx_cyc;
      chk("tmo_delay_in_window", (d >= TMO && d <= TMO + 4), 1);
    end
    chk("tmo_wr_count", wr_q.size(), 0);
    chk("tmo_error", bus.error, 1);
    chk("tmo_hold", bus.cpu_hold, 1);

    // Asynchronous reset in the middle of DATA
    clear_obs();
    mk(128'hA5_02_00_13_05_10_00_93, 8);
    play(0, 8, 1);
    chk("mid_wr_before_clr", wr_q.size(), 1);
    #2;
    clr = 1'b0;
    #1;
    chk("clr_hold", bus.cpu_hold, 1);
    chk("clr_done", bus.done, 0);
    chk("clr_we", bus.imem_we, 0);
    chk("clr_send", bus.send, 0);
    chk("clr_addr", bus.imem_addr, 0);
    chk("clr_wdata", bus.imem_wdata, 0);
    chk("clr_tx_data", bus.tx_data, 0);
    chk("clr_error", bus.error, 0);
    idle(2);
    clr = 1'b1;
    model_done = 0;
    model_err = 0;
    idle(1);
    mk(128'hA5_02_00_13_05_10_00_93_05_20_00_B0, 12);
    run("after_clr", 2);

    // Response held off by a busy transmitter
    do_reset();
    clear_obs();
    mk(128'hA5_01_00_EF_BE_AD_DE_22, 8);
    model();
    play(0, 7, 1);
    bus.tx_busy = 1'b1;
    play(7, 8, 0);
    idle(50);
    chk("busy_no_send", tx_q.size(), 0);
    bus.tx_busy = 1'b0;
    check_frame("busy");

    // Random frames
    for (int it = 0; it < 12; it++) begin
      if (model_done || ($urandom_range(3, 0) == 0)) do_reset();
      n = int'($urandom_range(5, 0));
      frm.delete();
      if ($urandom_range(2, 0) == 0) frm.push_back(8'h3C);
      frm.push_back(SYNC);
      frm.push_back(8'(n));
      frm.push_back(8'(n >> 8));
      x = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom);
        frm.push_back(b);
        x = x ^ b;
      end
      if ($urandom_range(1, 0) == 1) x = x ^ 8'(1 << $urandom_range(7, 0));
      frm.push_back(x);
      clear_obs();
      model();
      play(0, frm.size(), 3);
      check_frame("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
